// File: rtl/gate_shift_chain.sv
// Reduces a WIDTH-bit word to one feature bit with a selectable gate function and
// shifts it through a DEPTH-stage chain, tracking saturating fill and live popcount.
module gate_shift_chain #(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 2,
  localparam int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WIDTH-1:0]  in,
  input  logic [1:0]        mode,
  input  logic              shift_en,
  input  logic              clear,
  output logic              out,
  output logic [DEPTH-1:0]  state,
  output logic [CNTW-1:0]   fill,
  output logic              valid,
  output logic [CNTW-1:0]   ones
);

  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] ONE  = CNTW'(1);

  logic [DEPTH-1:0] state_r;
  logic [CNTW-1:0]  fill_r;
  logic             f_s;

  function automatic logic [CNTW-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CNTW-1:0] acc;
    acc = {CNTW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      acc = acc + CNTW'(v[i]);
    end
    return acc;
  endfunction

  // Feature bit selection; mode 0 is high when the word is mixed (not all-0, not all-1)
  always_comb begin
    f_s = 1'b0;
    case (mode)
      2'd0:    f_s = (&in) ^ (|in);
      2'd1:    f_s = &in;
      2'd2:    f_s = |in;
      2'd3:    f_s = ^in;
      default: f_s = 1'b0;
    endcase
  end

  // Shift chain and saturating fill counter; clear outranks shift_en
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= {DEPTH{1'b0}};
      fill_r  <= {CNTW{1'b0}};
    end else if (clear) begin
      state_r <= {DEPTH{1'b0}};
      fill_r  <= {CNTW{1'b0}};
    end else if (shift_en) begin
      state_r <= {state_r[DEPTH-2:0], f_s};
      if (fill_r != FULL) begin
        fill_r <= fill_r + ONE;
      end else begin
        fill_r <= fill_r;
      end
    end else begin
      state_r <= state_r;
      fill_r  <= fill_r;
    end
  end

  assign state = state_r;
  assign out   = state_r[DEPTH-1];
  assign fill  = fill_r;
  assign valid = (fill_r == FULL);
  assign ones  = popcount(state_r);

endmodule

// File: tb/tb_gate_shift_chain.sv
// Directed bench for gate_shift_chain: a default 2x2 instance and a 4x4 instance
// driven from hand-computed vectors.
module tb_gate_shift_chain;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  logic [1:0] in2;
  logic [1:0] mode2;
  logic       se2, clr2;
  logic       out2, valid2;
  logic [1:0] state2, fill2, ones2;

  logic [3:0] in4;
  logic [1:0] mode4;
  logic       se4, clr4;
  logic       out4, valid4;
  logic [3:0] state4;
  logic [2:0] fill4, ones4;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  gate_shift_chain #(.WIDTH(2), .DEPTH(2)) u_d2 (
    .CLK(CLK), .RST(RST), .in(in2), .mode(mode2), .shift_en(se2), .clear(clr2),
    .out(out2), .state(state2), .fill(fill2), .valid(valid2), .ones(ones2)
  );

  gate_shift_chain #(.WIDTH(4), .DEPTH(4)) u_d4 (
    .CLK(CLK), .RST(RST), .in(in4), .mode(mode4), .shift_en(se4), .clear(clr4),
    .out(out4), .state(state4), .fill(fill4), .valid(valid4), .ones(ones4)
  );

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    in2 = 2'b00; mode2 = 2'd0; se2 = 1'b0; clr2 = 1'b0;
    in4 = 4'b0000; mode4 = 2'd0; se4 = 1'b0; clr4 = 1'b0;

    // Reset values while RST is held
    #2;
    check_vec("rst_state2", 32'(state2), 32'h0);
    check_vec("rst_fill2",  32'(fill2),  32'h0);
    check_vec("rst_state4", 32'(state4), 32'h0);
    check_vec("rst_valid4", 32'(valid4), 32'h0);
    check_vec("rst_ones4",  32'(ones4),  32'h0);
    step();
    step();
    RST = 1'b0;

    // Default config: mode 0, in=01 then 11
    se2 = 1'b1; in2 = 2'b01;
    step();
    check_vec("d2_e1_state", 32'(state2), 32'h1);
    check_vec("d2_e1_fill",  32'(fill2),  32'h1);
    check_vec("d2_e1_valid", 32'(valid2), 32'h0);
    in2 = 2'b11;
    step();
    check_vec("d2_e2_state", 32'(state2), 32'h2);
    check_vec("d2_e2_out",   32'(out2),   32'h1);
    check_vec("d2_e2_fill",  32'(fill2),  32'h2);
    check_vec("d2_e2_valid", 32'(valid2), 32'h1);
    check_vec("d2_e2_ones",  32'(ones2),  32'h1);
    se2 = 1'b0;

    // Fill and saturation on DEPTH=4, OR mode feeding ones
    mode4 = 2'd2; in4 = 4'b0001; se4 = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      check_vec($sformatf("sat_fill_e%0d", i),  32'(fill4),  32'((i < 4) ? i : 4));
      check_vec($sformatf("sat_valid_e%0d", i), 32'(valid4), 32'((i >= 4) ? 1 : 0));
      check_vec($sformatf("sat_out_e%0d", i),   32'(out4),   32'((i >= 4) ? 1 : 0));
    end
    check_vec("sat_ones", 32'(ones4), 32'h4);

    // Hold for 3 edges, then clear beats shift_en
    se4 = 1'b0; in4 = 4'b0000;
    for (int i = 1; i <= 3; i++) begin
      step();
      check_vec($sformatf("hold_state_e%0d", i), 32'(state4), 32'hf);
      check_vec($sformatf("hold_fill_e%0d", i),  32'(fill4),  32'h4);
    end
    clr4 = 1'b1; se4 = 1'b1; in4 = 4'b1111;
    step();
    check_vec("clr_state", 32'(state4), 32'h0);
    check_vec("clr_fill",  32'(fill4),  32'h0);
    check_vec("clr_valid", 32'(valid4), 32'h0);
    check_vec("clr_ones",  32'(ones4),  32'h0);
    clr4 = 1'b0;

    // Mode sweep with in=1011: f = 1,0,1,1
    in4 = 4'b1011;
    mode4 = 2'd0; step(); check_vec("sweep_m0", 32'(state4), 32'h1);
    mode4 = 2'd1; step(); check_vec("sweep_m1", 32'(state4), 32'h2);
    mode4 = 2'd2; step(); check_vec("sweep_m2", 32'(state4), 32'h5);
    mode4 = 2'd3; step(); check_vec("sweep_m3", 32'(state4), 32'hb);
    check_vec("sweep_ones",  32'(ones4),  32'h3);
    check_vec("sweep_valid", 32'(valid4), 32'h1);
    in4 = 4'b1111; mode4 = 2'd0;
    step();
    check_vec("m0_allones", 32'(state4), 32'h6);

    // Mid-fill asynchronous reset between edges
    clr4 = 1'b1; step(); clr4 = 1'b0;
    mode4 = 2'd2;
    in4 = 4'b0001; step();
    in4 = 4'b0000; step();
    in4 = 4'b0001; step();
    se4 = 1'b0;
    check_vec("pre_rst_state", 32'(state4), 32'h5);
    check_vec("pre_rst_fill",  32'(fill4),  32'h3);
    #2 RST = 1'b1;
    #1;
    check_vec("arst_state", 32'(state4), 32'h0);
    check_vec("arst_out",   32'(out4),   32'h0);
    check_vec("arst_fill",  32'(fill4),  32'h0);
    check_vec("arst_valid", 32'(valid4), 32'h0);
    check_vec("arst_ones",  32'(ones4),  32'h0);
    check_vec("arst_fill2", 32'(fill2),  32'h0);
    #1 RST = 1'b0;

    // Mode change mid-stream leaves stored bits alone
    se4 = 1'b1; mode4 = 2'd2; in4 = 4'b0001;
    step();
    mode4 = 2'd1; in4 = 4'b0111;
    step();
    check_vec("mchg_s1", 32'(state4[1]), 32'h1);
    check_vec("mchg_s0", 32'(state4[0]), 32'h0);
    check_vec("mchg_fill", 32'(fill4), 32'h2);
    se4 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
